primitive_bank_checker: RTL and testbench

//   Self-checking stimulus/response engine for the 4-input primitive gate bank (CLK/RST, in1..in4 -> out0..out7).

---
 rtl/primitive_chk_pkg.sv | 19 +
 rtl/primitive_golden_model.sv | 11 +
 rtl/primitive_bank_checker.sv | 114 +++++++++++
 tb/tb_primitive_bank_checker.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/primitive_chk_pkg.sv
// rtl/primitive_chk_pkg.sv - shared constants, state codes and golden response for the primitive bank checker
package primitive_chk_pkg;

    localparam int NUM_VEC = 16;
    localparam int RESP_W  = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_CHECK  = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    // x = {in4,in3,in2,in1}; bit order matches {out7..out0}
    function automatic logic [RESP_W-1:0] golden_resp(input logic [3:0] x);
        golden_resp = {x[0], ~x[0], ~^x, ^x, ~|x, |x, ~&x, &x};
    endfunction

endpackage

// File: rtl/primitive_golden_model.sv
// rtl/primitive_golden_model.sv - combinational expected response of the gate bank for one input vector
module primitive_golden_model
    import primitive_chk_pkg::*;
(
    input  logic [3:0]        vec,
    output logic [RESP_W-1:0] exp_resp
);

    assign exp_resp = golden_resp(vec);

endmodule

// File: rtl/primitive_bank_checker.sv
// rtl/primitive_bank_checker.sv - sweeps all 16 input vectors into the gate bank and checks each response
module primitive_bank_checker
    import primitive_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 8
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic              in1,
    output logic              in2,
    output logic              in3,
    output logic              in4,
    input  logic              out0,
    input  logic              out1,
    input  logic              out2,
    input  logic              out3,
    input  logic              out4,
    input  logic              out5,
    input  logic              out6,
    input  logic              out7,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [3:0]        fail_vec,
    output logic [RESP_W-1:0] fail_resp,
    output logic              fail_seen
);

    localparam int                CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]        LAST_VEC = 4'(NUM_VEC - 1);

    state_t            state;
    logic [3:0]        vec;
    logic [CNT_W-1:0]  settle_cnt;
    logic [RESP_W-1:0] resp;
    logic [RESP_W-1:0] exp_resp;
    logic              mismatch;

    assign resp = {out7, out6, out5, out4, out3, out2, out1, out0};

    primitive_golden_model u_golden (
        .vec      (vec),
        .exp_resp (exp_resp)
    );

    // Four-state compare so an undriven or X response bit is flagged
    assign mismatch = (resp !== exp_resp);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_resp  <= '0;
            fail_seen  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_SETTLE;
                        vec        <= '0;
                        settle_cnt <= CNT_LOAD;
                        err_count  <= '0;
                        fail_vec   <= '0;
                        fail_resp  <= '0;
                        fail_seen  <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        if (!fail_seen) begin
                            fail_vec  <= vec;
                            fail_resp <= resp;
                            fail_seen <= 1'b1;
                        end
                    end
                    if (vec == LAST_VEC) begin
                        state <= ST_DONE;
                    end else begin
                        vec        <= vec + 4'd1;
                        settle_cnt <= CNT_LOAD;
                        state      <= ST_SETTLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The vector register doubles as the pin register: it only moves when leaving IDLE/DONE or CHECK
    assign {in4, in3, in2, in1} = vec;

    assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_primitive_bank_checker.sv
// tb/tb_primitive_bank_checker.sv - randomized fault-injection bench for primitive_bank_checker
module tb_primitive_bank_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic [3:0] pins_a, pins_b;
    logic [7:0] resp_a, resp_b;
    logic       busy_a, done_a, pass_a, fseen_a;
    logic       busy_b, done_b, pass_b, fseen_b;
    logic [7:0] err_a;
    logic [1:0] err_b;
    logic [3:0] fvec_a, fvec_b;
    logic [7:0] fresp_a, fresp_b;

    logic [7:0] flip_a [16];
    logic [7:0] flip_b [16];
    logic [7:0] b_s1, b_s2;

    int vectors = 0;
    int miscompares = 0;

    // Reference response derived from the ones-count of the input vector
    function automatic logic [7:0] ref_resp(input logic [3:0] x);
        int  n;
        logic all_one, any_one, odd;
        n = 0;
        for (int k = 0; k < 4; k++) n += int'(x[k]);
        all_one = (n == 4);
        any_one = (n > 0);
        odd     = (n % 2) == 1;
        return {x[0], !x[0], !odd, odd, !any_one, any_one, !all_one, all_one};
    endfunction

    assign resp_a = ref_resp(pins_a) ^ flip_a[pins_a];

    always @(posedge clk) begin
        b_s1 <= ref_resp(pins_b) ^ flip_b[pins_b];
        b_s2 <= b_s1;
    end
    assign resp_b = b_s2;

    primitive_bank_checker #(.SETTLE_CYCLES(1), .ERR_W(8)) dut_a (
        .CLK(clk), .RST(rst), .start(start_a),
        .in1(pins_a[0]), .in2(pins_a[1]), .in3(pins_a[2]), .in4(pins_a[3]),
        .out0(resp_a[0]), .out1(resp_a[1]), .out2(resp_a[2]), .out3(resp_a[3]),
        .out4(resp_a[4]), .out5(resp_a[5]), .out6(resp_a[6]), .out7(resp_a[7]),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .fail_vec(fvec_a), .fail_resp(fresp_a), .fail_seen(fseen_a)
    );

    primitive_bank_checker #(.SETTLE_CYCLES(3), .ERR_W(2)) dut_b (
        .CLK(clk), .RST(rst), .start(start_b),
        .in1(pins_b[0]), .in2(pins_b[1]), .in3(pins_b[2]), .in4(pins_b[3]),
        .out0(resp_b[0]), .out1(resp_b[1]), .out2(resp_b[2]), .out3(resp_b[3]),
        .out4(resp_b[4]), .out5(resp_b[5]), .out6(resp_b[6]), .out7(resp_b[7]),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_vec(fvec_b), .fail_resp(fresp_b), .fail_seen(fseen_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pins_of(input int w);  return w != 0 ? pins_b : pins_a;   endfunction
    function automatic logic busy_of(input int w);         return w != 0 ? busy_b : busy_a;   endfunction
    function automatic logic done_of(input int w);         return w != 0 ? done_b : done_a;   endfunction
    function automatic logic [7:0] err_of(input int w);    return w != 0 ? {6'd0, err_b} : err_a; endfunction
    function automatic logic [7:0] flip_of(input int w, input int v);
        return w != 0 ? flip_b[v] : flip_a[v];
    endfunction

    task automatic set_start(input int w, input logic v);
        if (w != 0) start_b = v; else start_a = v;
    endtask

    task automatic fill_random(input int w);
        for (int v = 0; v < 16; v++) begin
            logic [7:0] f;
            f = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            if (w != 0) flip_b[v] = f; else flip_a[v] = f;
        end
    endtask

    task automatic fill_const(input int w, input logic [7:0] f);
        for (int v = 0; v < 16; v++) begin
            if (w != 0) flip_b[v] = f; else flip_a[v] = f;
        end
    endtask

    task automatic check_result(input int w, input string name);
        int n_err, first, cap;
        n_err = 0;
        first = -1;
        cap   = (w != 0) ? 3 : 255;
        for (int v = 0; v < 16; v++) begin
            if (flip_of(w, v) != 8'h00) begin
                n_err++;
                if (first < 0) first = v;
            end
        end
        check({name, "_done"}, done_of(w), 1);
        check({name, "_busy"}, busy_of(w), 0);
        check({name, "_err"}, err_of(w), (n_err > cap) ? cap : n_err);
        check({name, "_pass"}, (w != 0) ? pass_b : pass_a, n_err == 0);
        check({name, "_fseen"}, (w != 0) ? fseen_b : fseen_a, first >= 0);
        check({name, "_fvec"}, (w != 0) ? fvec_b : fvec_a, (first >= 0) ? first : 0);
        check({name, "_fresp"}, (w != 0) ? fresp_b : fresp_a,
              (first >= 0) ? 32'(ref_resp(4'(first)) ^ flip_of(w, first)) : 32'd0);
    endtask

    // One full sweep; pins and busy are checked on every cycle of every settle window
    task automatic sweep(input int w, input bit poke, input string name);
        int per_vec;
        per_vec = (w != 0) ? 4 : 2;
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        for (int i = 0; i < 16 * per_vec; i++) begin
            check($sformatf("%s_pins_c%0d", name, i), pins_of(w), i / per_vec);
            check($sformatf("%s_busy_c%0d", name, i), {busy_of(w), done_of(w)}, 2'b10);
            if (poke) set_start(w, i == 9);
            @(negedge clk);
        end
        check_result(w, name);
    endtask

    initial begin
        int  cyc;
        bit  saw_done;

        fill_const(0, 8'h00);
        fill_const(1, 8'h00);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_a", {busy_a, done_a, pass_a, fseen_a, pins_a, err_a, fvec_a, fresp_a}, 0);
        check("rst_b", {busy_b, done_b, pass_b, fseen_b, pins_b, err_b, fvec_b, fresp_b}, 0);
        rst = 1'b0;
        @(negedge clk);

        sweep(0, 1'b0, "a_clean");

        for (int v = 0; v < 16; v++) flip_a[v] = ref_resp(4'(v)) & 8'h10;
        sweep(0, 1'b1, "a_out4_sa0");

        // Restart from DONE with start held high; the error count must clear on the restart edge
        start_a = 1'b1;
        @(negedge clk);
        check("restart_state", {busy_a, done_a, fseen_a, pins_a}, 7'b1000000);
        check("restart_err", err_a, 0);
        @(negedge clk);
        start_a = 1'b0;
        cyc = 1;
        while (!done_a && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("restart_latency", cyc, 32);
        check_result(0, "a_restart");

        for (int r = 0; r < 3; r++) begin
            fill_random(0);
            sweep(0, r == 1, $sformatf("a_rand%0d", r));
        end

        sweep(1, 1'b0, "b_clean");
        fill_const(1, 8'h40);
        sweep(1, 1'b0, "b_out6_inv");
        for (int r = 0; r < 2; r++) begin
            fill_random(1);
            sweep(1, 1'b1, $sformatf("b_rand%0d", r));
        end

        // Abort mid-sweep while vector 7 is settling
        fill_random(0);
        flip_a[0] = 8'hff;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (14) @(negedge clk);
        check("abort_pre", {busy_a, pins_a}, {1'b1, 4'd7});
        check("abort_pre_err", err_a != 0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_post", {busy_a, done_a, pass_a, fseen_a, pins_a, err_a, fvec_a, fresp_a}, 0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_a || busy_a) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
